// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state codes, baud default and parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_CLKS_PER_BIT = 87;

    // Codes 0..5 are shared with uart_tx; s_WAIT_IDLE exists only in the receiver.
    typedef enum logic [2:0] {
        s_IDLE          = 3'b000,
        s_RX_START_BIT  = 3'b001,
        s_RX_DATA_BITS  = 3'b010,
        s_RX_PARITY_BIT = 3'b011,
        s_RX_STOP_BIT   = 3'b100,
        s_CLEANUP       = 3'b101,
        s_WAIT_IDLE     = 3'b110
    } uart_state_t;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for asynchronous inputs, resets to ones.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync #(
    parameter int unsigned            WIDTH       = 1,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Async,
    output logic [WIDTH-1:0] o_Sync
);

    logic [WIDTH-1:0] r_Meta;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_Meta <= RESET_VALUE;
            o_Sync <= RESET_VALUE;
        end else begin
            r_Meta <= i_Async;
            o_Sync <= r_Meta;
        end
    end

endmodule : uart_rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8O1 UART receiver, mid-bit sampling, parity and stop checks.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Parity_Err,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [8:0] c_HALF = 9'((CLKS_PER_BIT - 1) / 2);
    localparam logic [8:0] c_LAST = 9'(CLKS_PER_BIT - 1);

    logic        r_Rx;
    uart_state_t r_State;
    logic [8:0]  r_Clock_Count;
    logic [2:0]  r_Bit_Index;
    logic [7:0]  r_Rx_Data;
    logic        r_Parity_Err;

    uart_rx_sync #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_Rx_Serial),
        .o_Sync  (r_Rx)
    );

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_State         <= s_IDLE;
            r_Clock_Count   <= 9'd0;
            r_Bit_Index     <= 3'd0;
            r_Rx_Data       <= 8'h00;
            r_Parity_Err    <= 1'b0;
            o_Rx_DV         <= 1'b0;
            o_Rx_Byte       <= 8'h00;
            o_Rx_Parity_Err <= 1'b0;
            o_Rx_Frame_Err  <= 1'b0;
            o_Rx_Active     <= 1'b0;
        end else begin
            o_Rx_DV <= 1'b0;
            case (r_State)
                s_IDLE: begin
                    r_Clock_Count <= 9'd0;
                    r_Bit_Index   <= 3'd0;
                    if (!r_Rx) begin
                        r_State     <= s_RX_START_BIT;
                        o_Rx_Active <= 1'b1;
                    end
                end

                // Re-check the line at mid start bit so short glitches are dropped.
                s_RX_START_BIT: begin
                    if (r_Clock_Count == c_HALF) begin
                        r_Clock_Count <= 9'd0;
                        if (!r_Rx) begin
                            r_State <= s_RX_DATA_BITS;
                        end else begin
                            r_State     <= s_IDLE;
                            o_Rx_Active <= 1'b0;
                        end
                    end else begin
                        r_Clock_Count <= r_Clock_Count + 9'd1;
                    end
                end

                s_RX_DATA_BITS: begin
                    if (r_Clock_Count == c_LAST) begin
                        r_Clock_Count          <= 9'd0;
                        r_Rx_Data[r_Bit_Index] <= r_Rx;
                        if (r_Bit_Index != 3'd7) begin
                            r_Bit_Index <= r_Bit_Index + 3'd1;
                        end else begin
                            r_Bit_Index <= 3'd0;
                            r_State     <= s_RX_PARITY_BIT;
                        end
                    end else begin
                        r_Clock_Count <= r_Clock_Count + 9'd1;
                    end
                end

                s_RX_PARITY_BIT: begin
                    if (r_Clock_Count == c_LAST) begin
                        r_Clock_Count <= 9'd0;
                        r_Parity_Err  <= (r_Rx != odd_parity(r_Rx_Data));
                        r_State       <= s_RX_STOP_BIT;
                    end else begin
                        r_Clock_Count <= r_Clock_Count + 9'd1;
                    end
                end

                s_RX_STOP_BIT: begin
                    if (r_Clock_Count == c_LAST) begin
                        r_Clock_Count   <= 9'd0;
                        o_Rx_Byte       <= r_Rx_Data;
                        o_Rx_Frame_Err  <= ~r_Rx;
                        o_Rx_Parity_Err <= r_Parity_Err;
                        o_Rx_DV         <= 1'b1;
                        r_State         <= s_CLEANUP;
                    end else begin
                        r_Clock_Count <= r_Clock_Count + 9'd1;
                    end
                end

                // A low stop bit may be a break; wait for the line to recover.
                s_CLEANUP: begin
                    if (o_Rx_Frame_Err) begin
                        r_State <= s_WAIT_IDLE;
                    end else begin
                        r_State     <= s_IDLE;
                        o_Rx_Active <= 1'b0;
                    end
                end

                s_WAIT_IDLE: begin
                    if (r_Rx) begin
                        r_State     <= s_IDLE;
                        o_Rx_Active <= 1'b0;
                    end
                end

                default: begin
                    r_State       <= s_IDLE;
                    r_Clock_Count <= 9'd0;
                    r_Bit_Index   <= 3'd0;
                    o_Rx_Active   <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Randomised self-checking bench for uart_rx at 87 and 4 clk/bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    typedef struct {
        logic [7:0]  b;
        logic        pe;
        logic        fe;
        int unsigned t;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx0 = 1'b1;
    logic        rx1 = 1'b1;
    int unsigned cyc = 0;

    logic       dv0, pe0, fe0, act0;
    logic [7:0] byte0;
    logic       dv1, pe1, fe1, act1;
    logic [7:0] byte1;

    rec_t exp0[$], got0[$], exp1[$], got1[$];

    int n_vec = 0;
    int n_err = 0;

    uart_rx #(.CLKS_PER_BIT(87)) dut87 (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_Rx_Serial     (rx0),
        .o_Rx_DV         (dv0),
        .o_Rx_Byte       (byte0),
        .o_Rx_Parity_Err (pe0),
        .o_Rx_Frame_Err  (fe0),
        .o_Rx_Active     (act0)
    );

    uart_rx #(.CLKS_PER_BIT(4)) dut4 (
        .i_Clock         (clk),
        .i_Reset         (rst),
        .i_Rx_Serial     (rx1),
        .o_Rx_DV         (dv1),
        .o_Rx_Byte       (byte1),
        .o_Rx_Parity_Err (pe1),
        .o_Rx_Frame_Err  (fe1),
        .o_Rx_Active     (act1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with a strobe is logged, so a two-cycle strobe shows up as an extra entry.
    always @(negedge clk) begin
        if (dv0) got0.push_back('{byte0, pe0, fe0, cyc});
        if (dv1) got1.push_back('{byte1, pe1, fe1, cyc});
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    function automatic int cpb_of(input int sel);
        return (sel == 0) ? 87 : 4;
    endfunction

    // Pin edge to strobe: 2 sync cycles + 2 + HALF + 10 bit times.
    function automatic int unsigned latency(input int sel);
        int c;
        c = cpb_of(sel);
        return 4 + (c - 1) / 2 + 10 * c;
    endfunction

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx0 = v;
        else          rx1 = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] data, input logic par,
                              input logic stop, input int gap);
        int   c;
        rec_t e;
        c = cpb_of(sel);
        drive(sel, 1'b0);
        e.b  = data;
        e.pe = (par != ~^data);
        e.fe = ~stop;
        e.t  = cyc + latency(sel);
        if (sel == 0) exp0.push_back(e);
        else          exp1.push_back(e);
        wait_cyc(c);
        for (int i = 0; i < 8; i++) begin
            drive(sel, data[i]);
            wait_cyc(c);
        end
        drive(sel, par);
        wait_cyc(c);
        drive(sel, stop);
        wait_cyc(c);
        drive(sel, 1'b1);
        wait_cyc(gap);
    endtask

    task automatic check_batch(input int sel, input string tag);
        rec_t e[$];
        rec_t a[$];
        if (sel == 0) begin
            e = exp0; a = got0; exp0.delete(); got0.delete();
        end else begin
            e = exp1; a = got1; exp1.delete(); got1.delete();
        end
        chk_eq({tag, "_dv_count"}, a.size(), e.size());
        for (int i = 0; i < e.size() && i < a.size(); i++) begin
            chk_eq({tag, "_byte"},   {24'd0, a[i].b}, {24'd0, e[i].b});
            chk_eq({tag, "_parerr"}, {31'd0, a[i].pe}, {31'd0, e[i].pe});
            chk_eq({tag, "_frmerr"}, {31'd0, a[i].fe}, {31'd0, e[i].fe});
            chk_eq({tag, "_dv_cycle"}, a[i].t, e[i].t);
        end
    endtask

    task automatic random_frames(input int sel, input int n, input string tag);
        logic [7:0] d;
        logic       p, s;
        int         g;
        for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? (~^d ^ 1'b1) : ~^d;
            s = ($urandom_range(0, 3) != 0);
            g = 2 + int'($urandom_range(0, 20)) + (s ? 0 : 5);
            send_frame(sel, d, p, s, g);
        end
        wait_cyc(12);
        check_batch(sel, tag);
    endtask

    initial begin
        logic [7:0] d5a;
        wait_cyc(3);
        rst = 1'b0;

        chk_eq("rst_dv",     {31'd0, dv0},   0);
        chk_eq("rst_byte",   {24'd0, byte0}, 0);
        chk_eq("rst_parerr", {31'd0, pe0},   0);
        chk_eq("rst_frmerr", {31'd0, fe0},   0);
        chk_eq("rst_active", {31'd0, act0},  0);

        send_frame(0, 8'hA5, 1'b1, 1'b1, 20);
        check_batch(0, "clean_a5");
        send_frame(0, 8'h01, 1'b1, 1'b1, 20);
        check_batch(0, "parity_01");

        // Abort a 0x5A frame half-way through bit 3 with a one-cycle reset.
        d5a = 8'h5A;
        drive(0, 1'b0);
        wait_cyc(87);
        for (int i = 0; i < 3; i++) begin
            drive(0, d5a[i]);
            wait_cyc(87);
        end
        drive(0, d5a[3]);
        wait_cyc(40);
        chk_eq("midframe_active", {31'd0, act0}, 1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        drive(0, 1'b1);
        chk_eq("midrst_dv",     {31'd0, dv0},   0);
        chk_eq("midrst_byte",   {24'd0, byte0}, 0);
        chk_eq("midrst_parerr", {31'd0, pe0},   0);
        chk_eq("midrst_frmerr", {31'd0, fe0},   0);
        chk_eq("midrst_active", {31'd0, act0},  0);
        wait_cyc(87 * 12);
        check_batch(0, "midrst_nodv");
        send_frame(0, 8'h33, 1'b1, 1'b1, 20);
        check_batch(0, "after_rst_33");

        // Low stop bit followed by a 3-bit-time break.
        send_frame(0, 8'hFF, 1'b1, 1'b0, 0);
        drive(0, 1'b0);
        wait_cyc(3 * 87);
        chk_eq("break_active", {31'd0, act0}, 1);
        drive(0, 1'b1);
        wait_cyc(6);
        chk_eq("break_recover_active", {31'd0, act0}, 0);
        wait_cyc(20);
        check_batch(0, "frame_err_ff");

        drive(0, 1'b0);
        wait_cyc(10);
        chk_eq("glitch_active", {31'd0, act0}, 1);
        wait_cyc(20);
        drive(0, 1'b1);
        wait_cyc(100);
        chk_eq("glitch_idle", {31'd0, act0}, 0);
        chk_eq("byte_held", {24'd0, byte0}, 32'hFF);
        check_batch(0, "false_start");
        send_frame(0, 8'h7E, ~^8'h7E, 1'b1, 20);
        check_batch(0, "after_glitch_7e");

        send_frame(0, 8'h00, ~^8'h00, 1'b1, 2);
        send_frame(0, 8'hFF, ~^8'hFF, 1'b1, 2);
        send_frame(0, 8'h55, ~^8'h55, 1'b1, 2);
        wait_cyc(12);
        check_batch(0, "b2b_87");
        random_frames(0, 6, "rand_87");

        send_frame(1, 8'h00, ~^8'h00, 1'b1, 2);
        send_frame(1, 8'hFF, ~^8'hFF, 1'b1, 2);
        send_frame(1, 8'h55, ~^8'h55, 1'b1, 2);
        wait_cyc(12);
        check_batch(1, "b2b_4");
        random_frames(1, 40, "rand_4");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
